instr_fetch_unit: RTL and testbench
===================================

Name: instr_fetch_unit

Overview:
- Sequential fetch stage on the producer side of the decode interface.
- Holds the PC and issues one instruction-memory request at a time over a valid/ready handshake.
- Buffers the returned word and presents it, with its PC and opcode field, to decode/controller through a valid/ready handshake.
- Accepts redirects (taken branch, JAL, JALR) from execute and flushes in-flight work.

Parameters:
- PC_W, 9, width of byte PC and imem_addr; PC wraps modulo 2^PC_W.
- INST_W, 32, instruction width.
- RESET_PC, 0, PC value loaded on reset; low 2 bits must be 0.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  reset: synchronous, active-low.
- imem_req_valid  output  1  request presented.
- imem_req_ready  input  1  memory accepts request.
- imem_addr  output  PC_W  byte address of request.
- imem_rsp_valid  input  1  response word valid; at most one per accepted request, ≥1 cycle after acceptance.
- imem_rsp_data  input  INST_W  response word.
- if_valid  output  1  instruction buffer full.
- if_ready  input  1  decode accepts instruction.
- if_instr  output  INST_W  buffered instruction.
- if_pc  output  PC_W  PC of if_instr.
- if_opcode  output  7  if_instr[6:0], to controller Opcode input.
- redirect_valid  input  1  change of flow from execute.
- redirect_pc  input  PC_W  target; bits [1:0] forced to 0 internally.

Behaviour:
- Reset (rst_n=0 at posedge):
  - state=REQ, pc=RESET_PC, kill=0.
  - if_valid=0, if_instr=32'h00000013 (NOP), if_pc=0.
  - imem_req_valid=0 during reset cycles.
  - Reset mid-transaction abandons the outstanding request. A response arriving after reset is deasserted is discarded only if kill is set, so the bench must not return stale responses after reset.
- State REQ:
  - imem_req_valid=1, imem_addr=pc.
  - On imem_req_ready: go WAIT.
  - imem_addr and pc are stable while valid and not ready.
- State WAIT:
  - imem_req_valid=0.
  - On imem_rsp_valid with kill=0: if_instr/if_pc load data and pc; pc<=pc+4 (wraps); if_valid=1 next cycle; go HOLD.
  - On imem_rsp_valid with kill=1: discard the word, kill<=0, go REQ.
- State HOLD:
  - if_valid=1; if_instr/if_pc stable until accepted.
  - On if_ready: if_valid<=0, go REQ.
- Latency: request acceptance → if_valid is 1 cycle after the rsp_valid cycle. Minimum 3 cycles per instruction with zero-wait memory; no overlap of fetch and hold.
- Redirect (highest priority, any state):
  - pc<=redirect_pc&~3; if_valid<=0.
  - REQ with ready low: go REQ with the new pc next cycle.
  - REQ with ready high (old-address request leaves): kill<=1, go WAIT.
  - WAIT with no rsp this cycle: kill<=1, stay WAIT.
  - WAIT with rsp this cycle: discard the word, kill stays 0, go REQ.
  - HOLD: drop the buffered instruction, go REQ. If if_ready is high the same cycle, the handshake still counts as consumed by decode; pc comes from the redirect.
- if_opcode is purely combinational from if_instr.
- No state consumes X: rsp_valid outside WAIT is ignored.

Test Plan:
- Reset, zero-wait memory returning word=addr: stream from 0 → if_pc 0x000, 0x004, 0x008 on successive handshakes, if_opcode=instr[6:0]; during reset if_valid=0, if_instr=0x00000013.
- imem_req_ready low 3 cycles at pc=0x010 → imem_addr held 0x010, imem_req_valid held 1, single request issued.
- if_ready low 5 cycles in HOLD → if_instr/if_pc stable, no new imem request; release → next request at pc+4.
- redirect_valid to 0x0A3 while WAIT for 0x020, response 2 cycles later → that response discarded, next request addr 0x0A0, delivered if_pc=0x0A0.
- redirect in the same cycle as imem_rsp_valid and again in the same cycle as REQ acceptance → both old words discarded, exactly one instruction delivered, from the final redirect target.
- PC_W=9, redirect to 0x1FC → delivered 0x1FC then 0x000 (wrap); rst_n low in WAIT → pc=RESET_PC, if_valid=0 next cycle.

Source files
------------

// File: rtl/instr_fetch_unit.sv
// Single-outstanding instruction fetch stage: issues one imem request, buffers the
// returned word, and hands it to decode; execute redirects flush in-flight work.
module instr_fetch_unit #(
    parameter int              PC_W     = 9,
    parameter int              INST_W   = 32,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req_valid,
    input  logic              imem_req_ready,
    output logic [PC_W-1:0]   imem_addr,
    input  logic              imem_rsp_valid,
    input  logic [INST_W-1:0] imem_rsp_data,
    output logic              if_valid,
    input  logic              if_ready,
    output logic [INST_W-1:0] if_instr,
    output logic [PC_W-1:0]   if_pc,
    output logic [6:0]        if_opcode,
    input  logic              redirect_valid,
    input  logic [PC_W-1:0]   redirect_pc
);

    typedef enum logic [1:0] {
        REQ,
        WAIT,
        HOLD
    } state_t;

    localparam logic [INST_W-1:0] NOP = INST_W'(32'h0000_0013);

    state_t          state;
    logic [PC_W-1:0] pc;
    logic            kill;
    logic [PC_W-1:0] redirect_tgt;

    assign redirect_tgt   = {redirect_pc[PC_W-1:2], 2'b00};
    // Gated by rst_n so no request is visible while reset is held.
    assign imem_req_valid = rst_n && (state == REQ);
    assign imem_addr      = pc;
    assign if_opcode      = if_instr[6:0];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= REQ;
            pc       <= RESET_PC;
            kill     <= 1'b0;
            if_valid <= 1'b0;
            if_instr <= NOP;
            if_pc    <= '0;
        end else if (redirect_valid) begin
            pc       <= redirect_tgt;
            if_valid <= 1'b0;
            case (state)
                REQ: begin
                    // Request for the old address leaves anyway; its response must be dropped.
                    if (imem_req_ready) begin
                        kill  <= 1'b1;
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        kill  <= 1'b0;
                        state <= REQ;
                    end else begin
                        kill <= 1'b1;
                    end
                end
                default: state <= REQ;
            endcase
        end else begin
            case (state)
                REQ: begin
                    if (imem_req_ready) state <= WAIT;
                end
                WAIT: begin
                    if (imem_rsp_valid) begin
                        if (kill) begin
                            kill  <= 1'b0;
                            state <= REQ;
                        end else begin
                            if_instr <= imem_rsp_data;
                            if_pc    <= pc;
                            pc       <= pc + PC_W'(4);
                            if_valid <= 1'b1;
                            state    <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (if_ready) begin
                        if_valid <= 1'b0;
                        state    <= REQ;
                    end
                end
                default: state <= REQ;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: streaming, stalls, redirects, wrap and reset.
module tb_instr_fetch_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [8:0]  imem_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        if_valid;
    logic        if_ready;
    logic [31:0] if_instr;
    logic [8:0]  if_pc;
    logic [6:0]  if_opcode;
    logic        redirect_valid;
    logic [8:0]  redirect_pc;

    int n_assert = 0;
    int n_fail   = 0;

    instr_fetch_unit #(
        .PC_W    (9),
        .INST_W  (32),
        .RESET_PC(9'h000)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_req_valid(imem_req_valid),
        .imem_req_ready(imem_req_ready),
        .imem_addr     (imem_addr),
        .imem_rsp_valid(imem_rsp_valid),
        .imem_rsp_data (imem_rsp_data),
        .if_valid      (if_valid),
        .if_ready      (if_ready),
        .if_instr      (if_instr),
        .if_pc         (if_pc),
        .if_opcode     (if_opcode),
        .redirect_valid(redirect_valid),
        .redirect_pc   (redirect_pc)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Memory returns the address tagged in the upper bits so instr and pc differ.
    function automatic logic [31:0] word(input logic [8:0] a);
        return 32'h5A00_0000 | {23'b0, a};
    endfunction

    task automatic fetch(input logic [8:0] pc, input int req_stall, input int rsp_delay,
                         input int hold_stall);
        logic [8:0]  nxt;
        logic [31:0] w;
        nxt = pc + 9'd4;
        w   = word(pc);
        chk("req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("req_addr", {23'b0, imem_addr}, {23'b0, pc});
        for (int i = 0; i < req_stall; i++) begin
            step();
            chk("stall_req_valid", {31'b0, imem_req_valid}, 32'd1);
            chk("stall_req_addr", {23'b0, imem_addr}, {23'b0, pc});
        end
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        chk("wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("wait_if_valid", {31'b0, if_valid}, 32'd0);
        for (int i = 0; i < rsp_delay; i++) begin
            step();
            chk("wait_req_valid_d", {31'b0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = w;
        step();
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        chk("hold_if_valid", {31'b0, if_valid}, 32'd1);
        chk("hold_if_pc", {23'b0, if_pc}, {23'b0, pc});
        chk("hold_if_instr", if_instr, w);
        chk("hold_if_opcode", {25'b0, if_opcode}, {25'b0, w[6:0]});
        chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
        for (int i = 0; i < hold_stall; i++) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = 32'hDEAD_BEEF;
            step();
            chk("stall_if_valid", {31'b0, if_valid}, 32'd1);
            chk("stall_if_instr", if_instr, w);
            chk("stall_if_pc", {23'b0, if_pc}, {23'b0, pc});
            chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
        end
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready = 1'b1;
        step();
        if_ready = 1'b0;
        chk("post_if_valid", {31'b0, if_valid}, 32'd0);
        chk("post_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("post_req_addr", {23'b0, imem_addr}, {23'b0, nxt});
    endtask

    initial begin
        rst_n          = 1'b0;
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b0;
        imem_rsp_data  = '0;
        if_ready       = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;

        // Reset
        step();
        step();
        chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_if_instr", if_instr, 32'h0000_0013);
        chk("rst_if_pc", {23'b0, if_pc}, 32'd0);
        chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        rst_n = 1'b1;
        #1;

        // Zero-wait stream, request stall at 0x010, hold stall at 0x014
        fetch(9'h000, 0, 0, 0);
        fetch(9'h004, 0, 0, 0);
        fetch(9'h008, 0, 0, 0);
        fetch(9'h00C, 0, 2, 0);
        fetch(9'h010, 3, 0, 0);
        fetch(9'h014, 0, 0, 5);
        fetch(9'h018, 0, 0, 0);
        fetch(9'h01C, 0, 0, 0);

        // Redirect while waiting for 0x020; late response must be dropped
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 9'h0A3;
        step();
        redirect_valid = 1'b0;
        chk("rw_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(9'h020);
        step();
        imem_rsp_valid = 1'b0;
        chk("rw_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rw_req_valid2", {31'b0, imem_req_valid}, 32'd1);
        chk("rw_req_addr", {23'b0, imem_addr}, 32'h0A0);
        fetch(9'h0A0, 0, 0, 0);

        // Redirect with response, then redirect with request acceptance
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(9'h0A4);
        redirect_valid = 1'b1;
        redirect_pc    = 9'h100;
        step();
        imem_rsp_valid = 1'b0;
        redirect_valid = 1'b0;
        chk("rr_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rr_req_addr", {23'b0, imem_addr}, 32'h100);
        chk("rr_req_valid", {31'b0, imem_req_valid}, 32'd1);
        imem_req_ready = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 9'h1FC;
        step();
        imem_req_ready = 1'b0;
        redirect_valid = 1'b0;
        chk("ra_req_valid", {31'b0, imem_req_valid}, 32'd0);
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(9'h100);
        step();
        imem_rsp_valid = 1'b0;
        chk("ra_if_valid", {31'b0, if_valid}, 32'd0);
        chk("ra_req_addr", {23'b0, imem_addr}, 32'h1FC);
        fetch(9'h1FC, 0, 0, 0);
        fetch(9'h000, 0, 0, 0);

        // Redirect in HOLD with if_ready high
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = word(9'h004);
        step();
        imem_rsp_valid = 1'b0;
        chk("rh_if_valid", {31'b0, if_valid}, 32'd1);
        chk("rh_if_pc", {23'b0, if_pc}, 32'h004);
        redirect_valid = 1'b1;
        redirect_pc    = 9'h040;
        if_ready       = 1'b1;
        step();
        redirect_valid = 1'b0;
        if_ready       = 1'b0;
        chk("rh_if_valid2", {31'b0, if_valid}, 32'd0);
        chk("rh_req_addr", {23'b0, imem_addr}, 32'h040);

        // Redirect in REQ with ready low
        redirect_valid = 1'b1;
        redirect_pc    = 9'h083;
        step();
        redirect_valid = 1'b0;
        chk("rq_req_valid", {31'b0, imem_req_valid}, 32'd1);
        chk("rq_req_addr", {23'b0, imem_addr}, 32'h080);
        fetch(9'h080, 0, 0, 0);

        // Reset while waiting
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        rst_n = 1'b0;
        step();
        chk("rw_rst_if_valid", {31'b0, if_valid}, 32'd0);
        chk("rw_rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        chk("rw_rst_if_instr", if_instr, 32'h0000_0013);
        rst_n = 1'b1;
        #1;
        chk("rw_rst_req_addr", {23'b0, imem_addr}, 32'h000);
        fetch(9'h000, 0, 1, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
